led_scan_ctrl: RTL and testbench
================================

# led_scan_ctrl

Sequencing controller for the board's 8-LED bank: holds a 3-bit position index and steps it at a programmable rate in one of four modes. The index drives a registered one-hot LED output. This block sits between the switch/button inputs and the LEDs and replaces direct switch-to-decoder wiring. Rate comes from an internal prescaler; software-free, switch-driven.

## Interface
- TICK_DIV, 12_500_000: clk cycles per automatic step (8 Hz at 100 MHz); legal range 1..2^26; counter width $clog2(TICK_DIV) (minimum 1).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = auto-step at prescaler rate, 0 = stopped.
- mode  in  2  00 up, 01 down, 10 bounce, 11 manual.
- manual_sel  in  3  position loaded in manual mode.
- step  in  1  single-cycle pulse (debounced upstream); advances one position while stopped.
- sel  out  3  current position index.
- led  out  8  registered one-hot of sel (led == 1<<sel at all times).
- wrap  out  1  one-cycle pulse on wrap-around or bounce reversal.

## Operation
- Reset values: sel=0, led=8'h01, wrap=0, dir=up, state=IDLE, prescaler=0.
- FSM: IDLE (run=0) and RUN (run=1); the transition follows run on every edge. Entering RUN clears the prescaler. In IDLE the prescaler holds at 0.
- RUN: the prescaler counts 0..TICK_DIV-1. An advance occurs on the cycle it equals TICK_DIV-1, and the count returns to 0.
- IDLE: step=1 causes one advance. step is ignored in RUN.
- Advance rules:
  - up: sel+1 mod 8; the 7->0 transition pulses wrap.
  - down: sel-1 mod 8; the 0->7 transition pulses wrap.
  - bounce: moves in direction dir. At sel=7 with dir=up, sel goes to 6, dir becomes down, and wrap pulses. At sel=0 with dir=down, sel goes to 1, dir becomes up, and wrap pulses.
  - manual: sel=manual_sel every cycle, regardless of state, run or step. The prescaler still runs but its advances have no effect. wrap stays 0.
- dir is forced to up on any cycle where mode != 10. Entering bounce therefore always starts upward; at sel=7 the first bounce advance goes to 6.
- sel and led are updated in the same edge from the same next-state value. led is never a different position than sel.
- Mode change mid-run takes effect at the next advance (or immediately for manual). The prescaler is not reset by a mode change.
- wrap is high for exactly the cycle after the advancing edge, so it is coincident with the new sel.

## Timing
- run 0->1: the first advance lands TICK_DIV edges after the first edge sampling run=1. Subsequent advances follow every TICK_DIV cycles.
- TICK_DIV=1: advance on every cycle while in RUN.
- step: sel, led and wrap update on the edge that samples step=1 (visible the next cycle).
- run falling on the same edge as a prescaler terminal count: the advance still occurs, then the FSM goes to IDLE.
- step and run=1 sampled together: the FSM is in RUN, so step is ignored.
- manual_sel to sel/led: 1-cycle latency.
- rst asserted mid-operation: all outputs go to reset values immediately (asynchronous). Operation resumes on the first edge after release.

## Configuration
- LED_SCAN_BOUNCE_EN defined: bounce mode and the dir register are present as described.
- Not defined: mode 10 behaves exactly as up; no dir register is built.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: assert rst for 3 cycles -> sel=0, led=8'h01, wrap=0. Release, hold run=0 for 10 cycles -> outputs unchanged.
- Up wrap: mode=00, run=1 for 33 cycles -> sel sequence 1..7,0 at 4-cycle spacing; led one-hot tracks sel; wrap pulses once, coincident with sel=0.
- Down plus step: run=0, mode=01, three step pulses starting from sel=0 -> sel 7, 6, 5; a single wrap pulse on the 0->7 transition.
- Bounce (macro defined): mode=10 from sel=5, run=1 -> sel 6,7,6,5,4,3,2,1,0,1; wrap pulses on the 7->6 and 0->1 transitions. Without the macro, the same stimulus gives 6,7,0,1… with a wrap pulse on 7->0.
- Manual: mode=11, manual_sel=3'b101 -> sel=5 and led=8'h20 one cycle later; run=1 for 20 cycles -> sel stays 5, wrap=0.
- Async reset: assert rst mid-run at sel=4 -> sel=0 and led=8'h01 before the next clk edge; a run pulse held through reset gives no advance until TICK_DIV cycles after release.

Source files
------------

// File: rtl/led_scan_ctrl_if.sv
// Control/status bundle for led_scan_ctrl: switch-side inputs and LED-side outputs.
interface led_scan_ctrl_if;
    logic       run;
    logic [1:0] mode;
    logic [2:0] manual_sel;
    logic       step;
    logic [2:0] sel;
    logic [7:0] led;
    logic       wrap;

    modport master (
        output run, mode, manual_sel, step,
        input  sel, led, wrap
    );

    modport slave (
        input  run, mode, manual_sel, step,
        output sel, led, wrap
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// 8-LED scan sequencer: prescaled or single-step position stepping in up/down/bounce/manual modes.
// Optional feature macro: LED_SCAN_BOUNCE_EN (bounce mode and direction register; otherwise mode 10 acts as up).
//
// state  | meaning
// S_IDLE | stopped; prescaler held at 0, step pulses advance one position
// S_RUN  | auto-stepping; prescaler wraps every TICK_DIV cycles and advances
module led_scan_ctrl #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic           clk,
    input  logic           rst,
    led_scan_ctrl_if.slave bus
);
    localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_sel;
    logic [2:0]       w_sel_nxt;
    logic [7:0]       r_led;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             w_adv;

`ifdef LED_SCAN_BOUNCE_EN
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    logic r_dir;
    logic w_dir_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= 3'd0;
            r_led   <= 8'h01;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_led   <= 8'd1 << w_sel_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

`ifdef LED_SCAN_BOUNCE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir <= DIR_UP;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = bus.run ? S_RUN : S_IDLE;
        w_cnt_nxt   = '0;
        w_adv       = 1'b0;
        w_sel_nxt   = r_sel;
        w_wrap_nxt  = 1'b0;
`ifdef LED_SCAN_BOUNCE_EN
        w_dir_nxt   = r_dir;
`endif

        // Step only counts while stopped and staying stopped; run=1 wins.
        if (r_state == S_RUN) begin
            w_adv     = (r_cnt == CNT_MAX);
            w_cnt_nxt = w_adv ? '0 : r_cnt + 1'b1;
        end else begin
            w_adv = bus.step && !bus.run;
        end

        if (bus.mode == 2'b11) begin
            w_sel_nxt = bus.manual_sel;
        end else if (w_adv) begin
            if (bus.mode == 2'b01) begin
                w_sel_nxt  = r_sel - 3'd1;
                w_wrap_nxt = (r_sel == 3'd0);
            end
`ifdef LED_SCAN_BOUNCE_EN
            else if (bus.mode == 2'b10) begin
                if (r_dir == DIR_UP) begin
                    if (r_sel == 3'd7) begin
                        w_sel_nxt  = 3'd6;
                        w_dir_nxt  = DIR_DOWN;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_sel_nxt = r_sel + 3'd1;
                    end
                end else begin
                    if (r_sel == 3'd0) begin
                        w_sel_nxt  = 3'd1;
                        w_dir_nxt  = DIR_UP;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_sel_nxt = r_sel - 3'd1;
                    end
                end
            end
`endif
            else begin
                w_sel_nxt  = r_sel + 3'd1;
                w_wrap_nxt = (r_sel == 3'd7);
            end
        end

`ifdef LED_SCAN_BOUNCE_EN
        if (bus.mode != 2'b10) begin
            w_dir_nxt = DIR_UP;
        end
`endif
    end

    assign bus.sel  = r_sel;
    assign bus.led  = r_led;
    assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (TICK_DIV=4): vector table, directed sequences, randomized run vs. reference model.
module tb_led_scan_ctrl;
    localparam int TICK = 4;

    logic clk;
    logic rst;
    led_scan_ctrl_if bus();

    led_scan_ctrl #(.TICK_DIV(TICK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position, direction (+1/-1), running flag and cycles spent running.
    int m_sel;
    int m_dir;
    int m_wrap;
    bit m_running;
    int m_age;

    typedef struct {
        bit       run;
        bit [1:0] mode;
        bit [2:0] msel;
        bit       step;
        int       exp_sel;
        int       exp_wrap;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel     = 0;
        m_dir     = 1;
        m_wrap    = 0;
        m_running = 1'b0;
        m_age     = 0;
    endtask

    task automatic model_edge();
        bit adv;
        int nxt;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_running) begin
            m_age++;
            adv = (m_age % TICK) == 0;
        end else begin
            adv   = bus.step && !bus.run;
            m_age = 0;
        end
        m_running = bus.run;
        m_wrap    = 0;
        if (bus.mode == 2'b11) begin
            m_sel = int'(bus.manual_sel);
        end else if (adv) begin
            if (bus.mode == 2'b01) begin
                m_wrap = (m_sel == 0);
                m_sel  = (m_sel + 7) % 8;
            end
`ifdef LED_SCAN_BOUNCE_EN
            else if (bus.mode == 2'b10) begin
                nxt = m_sel + m_dir;
                if (nxt > 7 || nxt < 0) begin
                    m_dir  = -m_dir;
                    nxt    = m_sel + m_dir;
                    m_wrap = 1;
                end
                m_sel = nxt;
            end
`endif
            else begin
                m_wrap = (m_sel == 7);
                m_sel  = (m_sel + 1) % 8;
            end
        end
        if (bus.mode != 2'b10) m_dir = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_sel", int'(bus.sel), m_sel);
        chk("model_led", int'(bus.led), 1 << m_sel);
        chk("model_wrap", int'(bus.wrap), m_wrap);
    endtask

    task automatic set_in(input bit run, input bit [1:0] mode, input bit [2:0] msel, input bit step);
        bus.run        = run;
        bus.mode       = mode;
        bus.manual_sel = msel;
        bus.step       = step;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int prev;
        int idx;
        int wcnt;
        int last_cyc;
        int up_seq[8];
        int bnc_seq[10];
        int bnc_w[10];

        rst = 1'b1;
        set_in(1'b0, 2'b00, 3'd0, 1'b0);
        model_reset();

        // Reset and idle hold
        for (int i = 0; i < 3; i++) tick();
        chk("rst_sel", int'(bus.sel), 0);
        chk("rst_led", int'(bus.led), 8'h01);
        chk("rst_wrap", int'(bus.wrap), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_sel", int'(bus.sel), 0);
            chk("idle_led", int'(bus.led), 8'h01);
        end

        // Step-driven vector table from sel=0
        vt[0]  = '{1'b0, 2'b01, 3'd0, 1'b1, 7, 1};
        vt[1]  = '{1'b0, 2'b01, 3'd0, 1'b0, 7, 0};
        vt[2]  = '{1'b0, 2'b01, 3'd0, 1'b1, 6, 0};
        vt[3]  = '{1'b0, 2'b01, 3'd0, 1'b1, 5, 0};
        vt[4]  = '{1'b0, 2'b00, 3'd0, 1'b1, 6, 0};
        vt[5]  = '{1'b0, 2'b00, 3'd0, 1'b1, 7, 0};
        vt[6]  = '{1'b0, 2'b00, 3'd0, 1'b1, 0, 1};
        vt[7]  = '{1'b0, 2'b11, 3'd5, 1'b0, 5, 0};
        vt[8]  = '{1'b0, 2'b11, 3'd2, 1'b1, 2, 0};
        vt[9]  = '{1'b0, 2'b00, 3'd0, 1'b1, 3, 0};
        vt[10] = '{1'b0, 2'b10, 3'd0, 1'b1, 4, 0};
        vt[11] = '{1'b0, 2'b00, 3'd0, 1'b0, 4, 0};
        for (int i = 0; i < 12; i++) begin
            set_in(vt[i].run, vt[i].mode, vt[i].msel, vt[i].step);
            tick();
            chk($sformatf("vec%0d_sel", i), int'(bus.sel), vt[i].exp_sel);
            chk($sformatf("vec%0d_led", i), int'(bus.led), 1 << vt[i].exp_sel);
            chk($sformatf("vec%0d_wrap", i), int'(bus.wrap), vt[i].exp_wrap);
        end
        set_in(1'b0, 2'b00, 3'd0, 1'b0);

        // Up wrap at 4-cycle spacing
        do_reset();
        up_seq = '{1, 2, 3, 4, 5, 6, 7, 0};
        set_in(1'b1, 2'b00, 3'd0, 1'b0);
        prev = int'(bus.sel);
        idx = 0;
        wcnt = 0;
        last_cyc = 0;
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (int'(bus.sel) != prev) begin
                if (idx < 8) chk("up_seq", int'(bus.sel), up_seq[idx]);
                if (idx > 0) chk("up_gap", c - last_cyc, TICK);
                last_cyc = c;
                idx++;
                prev = int'(bus.sel);
            end
            if (bus.wrap) begin
                wcnt++;
                chk("up_wrap_sel", int'(bus.sel), 0);
            end
        end
        chk("up_changes", idx, 8);
        chk("up_wraps", wcnt, 1);

        // Bounce from sel=5
        set_in(1'b0, 2'b11, 3'd5, 1'b0);
        tick();
        tick();
`ifdef LED_SCAN_BOUNCE_EN
        bnc_seq = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        bnc_w   = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
`else
        bnc_seq = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
        bnc_w   = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
`endif
        set_in(1'b1, 2'b10, 3'd0, 1'b0);
        prev = int'(bus.sel);
        idx = 0;
        for (int c = 1; c <= 41; c++) begin
            tick();
            if (int'(bus.sel) != prev) begin
                if (idx < 10) begin
                    chk("bnc_seq", int'(bus.sel), bnc_seq[idx]);
                    chk("bnc_wrap", int'(bus.wrap), bnc_w[idx]);
                end
                idx++;
                prev = int'(bus.sel);
            end
        end
        chk("bnc_changes", idx, 10);

        // Manual load and hold while running
        set_in(1'b0, 2'b11, 3'b101, 1'b0);
        tick();
        chk("man_sel", int'(bus.sel), 5);
        chk("man_led", int'(bus.led), 8'h20);
        bus.run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("man_hold_sel", int'(bus.sel), 5);
            chk("man_hold_wrap", int'(bus.wrap), 0);
        end

        // Async reset mid-run at sel=4, run held through reset
        do_reset();
        set_in(1'b1, 2'b00, 3'd0, 1'b0);
        for (int i = 0; i < 40 && m_sel != 4; i++) tick();
        chk("ar_reach4", int'(bus.sel), 4);
        #2 rst = 1'b1;
        #1;
        chk("ar_async_sel", int'(bus.sel), 0);
        chk("ar_async_led", int'(bus.led), 8'h01);
        chk("ar_async_wrap", int'(bus.wrap), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= TICK; i++) begin
            tick();
            chk("ar_noadv", int'(bus.sel), 0);
        end
        tick();
        chk("ar_first_adv", int'(bus.sel), 1);

        // Randomized run against the model
        set_in(1'b0, 2'b00, 3'd0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) bus.run = ~bus.run;
            if ($urandom_range(19) == 0) bus.mode = 2'($urandom_range(3));
            bus.step       = ($urandom_range(3) == 0);
            bus.manual_sel = 3'($urandom_range(7));
            if ($urandom_range(299) == 0) begin
                rst = 1'b1;
                #1 rst = 1'b0;
                model_reset();
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
